// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / taken-branch hazard controller driving PC, IF/ID and ID/EX enables, flushes and bubbles.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
   parameter int LOAD_LATENCY = 1,
   parameter int FLUSH_DEPTH  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic        ex_MemRead,
   input  logic [4:0]  ex_rd,
   input  logic        ex_branch_taken,
   input  logic        mem_busy,
   output logic        pc_write_en,
   output logic        if_id_write_en,
   output logic        if_id_flush,
   output logic        id_ex_write_en,
   output logic        id_ex_bubble,
   output logic [1:0]  hz_state,
   output logic [31:0] stall_count,
   output logic [31:0] flush_count
);

   localparam int MAX_LEN = (LOAD_LATENCY > FLUSH_DEPTH) ? LOAD_LATENCY : FLUSH_DEPTH;
   localparam int CW      = $clog2(MAX_LEN) + 1;
   localparam logic [CW-1:0] LS_INIT = CW'((LOAD_LATENCY > 1) ? LOAD_LATENCY - 2 : 0);
   localparam logic [CW-1:0] BF_INIT = CW'((FLUSH_DEPTH > 1) ? FLUSH_DEPTH - 2 : 0);

   typedef enum logic [1:0] {
      RUN        = 2'b00,
      LOAD_STALL = 2'b01,
      BR_FLUSH   = 2'b10
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          hazard;

   assign hazard = ex_MemRead && (ex_rd != 5'd0) &&
                   ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every output and next-state signal gets a default first, so no path infers a latch.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      pc_write_en    = 1'b1;
      if_id_write_en = 1'b1;
      if_id_flush    = 1'b0;
      id_ex_write_en = 1'b1;
      id_ex_bubble   = 1'b0;

      if (reset) begin
         pc_write_en    = 1'b0;
         if_id_write_en = 1'b0;
         if_id_flush    = 1'b1;
         id_ex_write_en = 1'b0;
         id_ex_bubble   = 1'b1;
      end else if (mem_busy) begin
         pc_write_en    = 1'b0;
         if_id_write_en = 1'b0;
         id_ex_write_en = 1'b0;
      end else if (ex_branch_taken) begin
         // A taken branch squashes whatever is in flight, including a pending load stall.
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         if (FLUSH_DEPTH > 1) begin
            state_d = BR_FLUSH;
            cnt_d   = BF_INIT;
         end else begin
            state_d = RUN;
            cnt_d   = '0;
         end
      end else begin
         unique case (state_q)
            RUN: begin
               if (hazard) begin
                  pc_write_en    = 1'b0;
                  if_id_write_en = 1'b0;
                  id_ex_bubble   = 1'b1;
                  if (LOAD_LATENCY > 1) begin
                     state_d = LOAD_STALL;
                     cnt_d   = LS_INIT;
                  end
               end
            end
            LOAD_STALL: begin
               pc_write_en    = 1'b0;
               if_id_write_en = 1'b0;
               id_ex_bubble   = 1'b1;
               if (cnt_q == '0) state_d = RUN;
               else             cnt_d   = cnt_q - CW'(1);
            end
            BR_FLUSH: begin
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
               if (cnt_q == '0) state_d = RUN;
               else             cnt_d   = cnt_q - CW'(1);
            end
            default: begin
               state_d = RUN;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign hz_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   // Outside reset, pc_write_en is low only for a mem_busy freeze or a load stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (!pc_write_en && !mem_busy) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (if_id_flush)               flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;
`else
   assign stall_count = 32'h0;
   assign flush_count = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: one vector table drives two instances (LOAD_LATENCY 1 and 3)
// whose expected outputs are queued at drive time and compared at the following falling edge.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_uses_rs1, id_uses_rs2, ex_MemRead, ex_branch_taken, mem_busy;

   logic        pc_a, ifid_a, flush_a, idex_a, bub_a;
   logic [1:0]  hz_a;
   logic [31:0] sc_a, fc_a;
   logic        pc_b, ifid_b, flush_b, idex_b, bub_b;
   logic [1:0]  hz_b;
   logic [31:0] sc_b, fc_b;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl dut_a (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_MemRead(ex_MemRead),
      .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
      .pc_write_en(pc_a), .if_id_write_en(ifid_a), .if_id_flush(flush_a),
      .id_ex_write_en(idex_a), .id_ex_bubble(bub_a), .hz_state(hz_a),
      .stall_count(sc_a), .flush_count(fc_a)
   );

   pipeline_hazard_ctrl #(.LOAD_LATENCY(3), .FLUSH_DEPTH(2)) dut_b (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_MemRead(ex_MemRead),
      .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
      .pc_write_en(pc_b), .if_id_write_en(ifid_b), .if_id_flush(flush_b),
      .id_ex_write_en(idex_b), .id_ex_bubble(bub_b), .hz_state(hz_b),
      .stall_count(sc_b), .flush_count(fc_b)
   );

   // Output groups {pc, if_id_we, if_id_flush, id_ex_we, bubble}.
   localparam logic [4:0] O_RUN = 5'b11010;
   localparam logic [4:0] O_STL = 5'b00011;
   localparam logic [4:0] O_BSY = 5'b00000;
   localparam logic [4:0] O_FLS = 5'b11111;
   localparam logic [4:0] O_RST = 5'b00101;

   typedef struct {
      logic       rst, mr;
      logic [4:0] rd, rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2, br, busy;
      logic [6:0] exp_a, exp_b;
   } vec_t;

   typedef struct {
      int         idx;
      logic       rst, busy;
      logic [6:0] exp_a, exp_b;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   exp_sa = 0, exp_fa = 0, exp_sb = 0, exp_fb = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, got, exp);
   endtask

   function automatic vec_t v(input logic rst, input logic mr, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                              input logic u2, input logic br, input logic busy,
                              input logic [6:0] ea, input logic [6:0] eb);
      vec_t r;
      r.rst = rst; r.mr = mr; r.rd = rd; r.rs1 = rs1; r.u1 = u1;
      r.rs2 = rs2; r.u2 = u2; r.br = br; r.busy = busy;
      r.exp_a = ea; r.exp_b = eb;
      return r;
   endfunction

   function automatic vec_t idle(input logic [6:0] ea, input logic [6:0] eb);
      return v(1'b0, 1'b0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, ea, eb);
   endfunction

   // Per-cycle increment of each perf counter implied by one expected output group.
   function automatic int stall_inc(input sb_t s, input logic [6:0] e);
      return (!s.rst && !s.busy && !e[6]) ? 1 : 0;
   endfunction

   function automatic int flush_inc(input sb_t s, input logic [6:0] e);
      return (!s.rst && e[4]) ? 1 : 0;
   endfunction

   initial begin
      reset = 1'b1; ex_MemRead = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;

      //                 rst   mr    rd     rs1    u1    rs2    u2    br    busy   dut_a            dut_b
      vecs.push_back(v(1'b1, 1'b0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, {O_RST,2'b00}, {O_RST,2'b00}));
      vecs.push_back(idle({O_RUN,2'b00}, {O_RUN,2'b00}));
      vecs.push_back(v(1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, {O_STL,2'b00}, {O_STL,2'b00}));
      vecs.push_back(idle({O_RUN,2'b00}, {O_STL,2'b01}));
      vecs.push_back(idle({O_RUN,2'b00}, {O_STL,2'b01}));
      vecs.push_back(idle({O_RUN,2'b00}, {O_RUN,2'b00}));
      vecs.push_back(v(1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, {O_RUN,2'b00}, {O_RUN,2'b00}));
      vecs.push_back(v(1'b0, 1'b1, 5'd7, 5'd5, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, {O_STL,2'b00}, {O_STL,2'b00}));
      for (int i = 0; i < 3; i++)
         vecs.push_back(v(1'b0, 1'b0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, {O_BSY,2'b00}, {O_BSY,2'b01}));
      vecs.push_back(idle({O_RUN,2'b00}, {O_STL,2'b01}));
      vecs.push_back(idle({O_RUN,2'b00}, {O_STL,2'b01}));
      vecs.push_back(idle({O_RUN,2'b00}, {O_RUN,2'b00}));
      vecs.push_back(v(1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, {O_FLS,2'b00}, {O_FLS,2'b00}));
      vecs.push_back(idle({O_FLS,2'b10}, {O_FLS,2'b10}));
      vecs.push_back(idle({O_RUN,2'b00}, {O_RUN,2'b00}));
      vecs.push_back(v(1'b0, 1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, {O_RUN,2'b00}, {O_RUN,2'b00}));
      vecs.push_back(v(1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, {O_STL,2'b00}, {O_STL,2'b00}));
      vecs.push_back(v(1'b0, 1'b0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, {O_FLS,2'b00}, {O_FLS,2'b01}));
      vecs.push_back(v(1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, {O_FLS,2'b10}, {O_FLS,2'b10}));
      vecs.push_back(v(1'b0, 1'b0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, {O_FLS,2'b00}, {O_FLS,2'b00}));
      vecs.push_back(v(1'b1, 1'b0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, {O_RST,2'b00}, {O_RST,2'b00}));
      vecs.push_back(idle({O_RUN,2'b00}, {O_RUN,2'b00}));
      vecs.push_back(v(1'b0, 1'b0, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, {O_RUN,2'b00}, {O_RUN,2'b00}));

      for (int i = 0; i < vecs.size(); i++) begin
         sb_t s;
         @(posedge clk);
         #1;
         reset           = vecs[i].rst;
         ex_MemRead      = vecs[i].mr;
         ex_rd           = vecs[i].rd;
         id_rs1          = vecs[i].rs1;
         id_uses_rs1     = vecs[i].u1;
         id_rs2          = vecs[i].rs2;
         id_uses_rs2     = vecs[i].u2;
         ex_branch_taken = vecs[i].br;
         mem_busy        = vecs[i].busy;
         s.idx = i; s.rst = vecs[i].rst; s.busy = vecs[i].busy;
         s.exp_a = vecs[i].exp_a; s.exp_b = vecs[i].exp_b;
         sb.push_back(s);

         @(negedge clk);
         if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
         end else begin
            s = sb.pop_front();
            check($sformatf("v%0d dut_a outputs", s.idx),
                  {25'd0, pc_a, ifid_a, flush_a, idex_a, bub_a, hz_a}, {25'd0, s.exp_a});
            check($sformatf("v%0d dut_b outputs", s.idx),
                  {25'd0, pc_b, ifid_b, flush_b, idex_b, bub_b, hz_b}, {25'd0, s.exp_b});
            if (s.rst) begin
               exp_sa = 0; exp_fa = 0; exp_sb = 0; exp_fb = 0;
            end
`ifdef HAZARD_PERF_CNT_EN
            check($sformatf("v%0d dut_a stall_count", s.idx), sc_a, exp_sa);
            check($sformatf("v%0d dut_a flush_count", s.idx), fc_a, exp_fa);
            check($sformatf("v%0d dut_b stall_count", s.idx), sc_b, exp_sb);
            check($sformatf("v%0d dut_b flush_count", s.idx), fc_b, exp_fb);
            exp_sa += stall_inc(s, s.exp_a);
            exp_fa += flush_inc(s, s.exp_a);
            exp_sb += stall_inc(s, s.exp_b);
            exp_fb += flush_inc(s, s.exp_b);
`else
            check($sformatf("v%0d dut_a counters", s.idx), sc_a | fc_a, 32'h0);
            check($sformatf("v%0d dut_b counters", s.idx), sc_b | fc_b, 32'h0);
`endif
         end
      end

      // Held hazard on the LOAD_LATENCY=3 instance: exactly three stall cycles, then release.
      @(posedge clk);
      #1;
      ex_MemRead = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
      id_uses_rs2 = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("held hazard c%0d dut_b pc_write_en", c), {31'd0, pc_b}, (c < 3) ? 32'd0 : 32'd1);
         @(posedge clk);
         #1;
         if (c == 2) ex_MemRead = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
